uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the TX FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have port wb_clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port clk_div  input  16  bit period in wb_clk_i cycles.
REQ-005 SHALL have port in_data  input  8  byte to transmit.
REQ-006 SHALL have port in_valid  input  1  in_data is offered.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a byte.
REQ-008 SHALL have port ser_tx  output  1  serial line, 8N1, idle high.
REQ-009 SHALL have port busy  output  1  frame in progress or FIFO not empty.
REQ-010 SHALL have port fifo_level  output  $clog2(DEPTH)+1  bytes currently queued.

Function
REQ-011 SHALL accept a byte on a rising edge where in_valid=1 and in_ready=1; no other condition writes the FIFO.
REQ-012 SHALL drive in_ready = (fifo_level != DEPTH), combinationally from registered state only.
REQ-013 SHALL hold in_data/in_valid changes with in_ready=0 without side effects (no drop, no duplicate).
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: ser_tx=1; if FIFO non-empty, pop head into shift register, latch effective divisor, go START.
REQ-016 SHALL use effective divisor = max(clk_div, 2), latched at the pop; clk_div changes mid-frame affect only later frames.
REQ-017 START: ser_tx=0 for exactly divisor cycles, then DATA.
REQ-018 DATA: 8 bits, LSB first, each held exactly divisor cycles; 3-bit bit counter; after bit 7 go STOP.
REQ-019 STOP: ser_tx=1 for exactly divisor cycles, then IDLE.
REQ-020 SHALL make a frame exactly 10*divisor cycles of START+DATA+STOP, with exactly one IDLE cycle between back-to-back frames.
REQ-021 Latency: byte accepted on edge N into an empty FIFO while IDLE -> popped on edge N+1, ser_tx low from edge N+1.
REQ-022 SHALL register ser_tx (glitch-free).
REQ-023 Simultaneous push and pop: both occur; fifo_level unchanged; read/write pointers wrap modulo DEPTH.
REQ-024 SHALL never pop an empty FIFO; push when full is impossible by REQ-012.
REQ-025 busy = (state != IDLE) or (fifo_level != 0).

Reset
REQ-026 On wb_rst_i=1, asynchronously: state=IDLE, ser_tx=1, FIFO flushed (pointers and fifo_level=0), counters=0, in_ready=1, busy=0.
REQ-027 Reset mid-frame SHALL abort the frame immediately (ser_tx high in the same cycle); queued bytes are discarded.
REQ-028 After deassertion, first byte is accepted on the first rising edge with in_valid=1.

Verification
REQ-029 Reset: assert wb_rst_i mid-simulation -> ser_tx=1, in_ready=1, busy=0, fifo_level=0 without a clock edge.
REQ-030 clk_div=4, push 0x55 -> ser_tx falls 1 cycle after accept; levels 0,1,0,1,0,1,0,1,0,1 each 4 cycles; line high after 40 cycles; busy drops then.
REQ-031 clk_div=3, push 6 bytes back-to-back (DEPTH=4) -> 5 accepted on consecutive edges, in_ready=0 on the 6th until first frame ends; all 6 transmitted in order, 1 idle cycle between frames.
REQ-032 clk_div=0 and clk_div=1, push 0xA3 -> bit period 2 cycles, frame 20 cycles, correct bits.
REQ-033 clk_div changed 4->8 mid-frame -> current frame stays at 4 cycles/bit, next frame uses 8.
REQ-034 Reset during DATA of 2nd of 3 queued bytes -> ser_tx high at once, fifo_level=0, no further frames after release.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte-wide TX FIFO feeding an 8N1 UART serialiser. The bit
//               period is programmable in clock cycles and is latched per
//               frame, so divisor changes only take effect on later frames.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [15:0]                clk_div,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       ser_tx,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    localparam logic [c_LW-1:0] c_DEPTH_LVL = c_LW'(DEPTH);
    localparam logic [15:0]     c_MIN_DIV   = 16'd2;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;

    // Serialiser state
    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [15:0] r_div;
    logic        r_tx;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  w_shift_nxt;
    logic [15:0] w_div_nxt;
    logic        w_tx_nxt;

    logic        w_push;
    logic        w_pop;
    logic        w_cnt_last;
    logic [15:0] w_div_eff;
    logic [7:0]  w_head;

    // in_ready depends only on the registered level, so a held in_valid
    // against a full FIFO can never sneak a write in.
    assign in_ready   = (r_level != c_DEPTH_LVL);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = (r_state == c_IDLE) && (r_level != '0);
    assign w_div_eff  = (clk_div < c_MIN_DIV) ? c_MIN_DIV : clk_div;
    assign w_cnt_last = (r_cnt == (r_div - 16'd1));
    assign w_head     = r_mem[r_rd_ptr];

    assign ser_tx     = r_tx;
    assign busy       = (r_state != c_IDLE) || (r_level != '0);
    assign fifo_level = r_level;

    // FIFO data array: contents need no reset, the pointers define validity
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and fill level; pointers wrap naturally at DEPTH
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Serialiser state register; ser_tx is registered to stay glitch-free
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_div   <= c_MIN_DIV;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_div   <= w_div_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Next-state logic: each phase lasts r_div cycles, counted 0..r_div-1
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_div_nxt   = r_div;
        w_tx_nxt    = r_tx;
        case (r_state)
            c_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_pop) begin
                    w_shift_nxt = w_head;
                    w_div_nxt   = w_div_eff;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = c_START;
                end
            end
            c_START: begin
                if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = c_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            c_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = c_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            c_STOP: begin
                if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = c_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo: frame table, burst,
//               divisor change, mid-frame reset and random traffic compared
//               against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [15:0] clk_div  = 16'd4;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ser_tx;
    logic        busy;
    logic [$clog2(DEPTH):0] fifo_level;

    int     n_vec    = 0;
    int     n_err    = 0;
    bit     chk_en   = 1'b0;
    longint edge_cnt = 0;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .clk_div    (clk_div),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_tx     (ser_tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // Frame-level reference: a byte queue plus the edge at which the current
    // frame was popped; the line level follows from (edge - pop) / divisor.
    logic [7:0] m_q [$];
    longint     m_cyc    = 0;
    longint     m_p      = 0;
    longint     m_d      = 2;
    longint     m_allow  = 0;
    logic [7:0] m_cur    = 8'h00;
    bit         m_active = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_allow  = 0;
        end else begin
            bit do_push;
            m_cyc++;
            do_push = in_valid && (m_q.size() < DEPTH);
            if (m_cyc >= m_allow && m_q.size() > 0) begin
                m_cur    = m_q.pop_front();
                m_p      = m_cyc;
                m_d      = (clk_div < 16'd2) ? 2 : longint'(clk_div);
                m_allow  = m_cyc + 10 * m_d + 1;
                m_active = 1'b1;
            end
            if (do_push) m_q.push_back(in_data);
        end
    end

    function automatic bit model_in_frame();
        return m_active && (m_cyc < m_p + 10 * m_d);
    endfunction

    function automatic logic model_tx();
        longint k;
        if (model_in_frame()) begin
            k = (m_cyc - m_p) / m_d;
            if (k == 0) return 1'b0;
            if (k <= 8) return m_cur[int'(k - 1)];
        end
        return 1'b1;
    endfunction

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_tx, exp_busy, exp_rdy;
            int   exp_lvl;
            exp_tx   = model_tx();
            exp_lvl  = m_q.size();
            exp_busy = model_in_frame() || (exp_lvl != 0);
            exp_rdy  = (exp_lvl != DEPTH);
            n_vec++;
            if (ser_tx !== exp_tx || busy !== exp_busy || in_ready !== exp_rdy ||
                fifo_level !== exp_lvl[$clog2(DEPTH):0]) begin
                n_err++;
                if (n_err <= 30)
                    $display("FAIL model_cycle %0d: got tx=%b busy=%b rdy=%b lvl=%0d, exp tx=%b busy=%b rdy=%b lvl=%0d",
                             m_cyc, ser_tx, busy, in_ready, fifo_level, exp_tx, exp_busy, exp_rdy, exp_lvl);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, exp 0x%0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired, got timeout, exp event", name);
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy !== 1'b0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) timeout("wait_idle");
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [7:0] b);
        logic rdy;
        int   w = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (w < 5000) begin
            rdy = in_ready;
            @(negedge clk);
            w++;
            if (rdy) break;
        end
        in_valid = 1'b0;
        if (w >= 5000) timeout("push");
    endtask

    // Sample-at-middle receiver; j=0 is the first negedge showing the start bit
    task automatic rx_frame(input int p, output logic [7:0] b);
        int w = 0;
        b = 8'h00;
        while (ser_tx !== 1'b0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) begin
            timeout("rx_start");
            return;
        end
        for (int j = 1; j <= 9 * p + p / 2; j++) begin
            @(negedge clk);
            if (j == p / 2) check("rx_start_low", ser_tx, 1'b0);
            if (j >= p && j < 9 * p && (j % p) == p / 2) b[j / p - 1] = ser_tx;
        end
        check("rx_stop_high", ser_tx, 1'b1);
    endtask

    typedef struct {
        logic [15:0] div;
        logic [7:0]  data;
        int          period;
    } vec_t;

    vec_t tbl [6];

    task automatic run_frame(input vec_t v);
        int         bad = 0;
        logic [7:0] rx  = 8'h00;
        logic       e;
        int         p   = v.period;
        wait_idle();
        clk_div = v.div;
        push(v.data);
        check("accept_edge_line_high", ser_tx, 1'b1);
        for (int j = 0; j <= 10 * p; j++) begin
            @(negedge clk);
            if (j < p)          e = 1'b0;
            else if (j < 9 * p) e = v.data[j / p - 1];
            else                e = 1'b1;
            if (ser_tx !== e) bad++;
            if (j >= p && j < 9 * p && (j % p) == p / 2) rx[j / p - 1] = ser_tx;
        end
        check("frame_wave_bad_cycles", bad, 0);
        check("frame_byte", rx, v.data);
        check("frame_busy_end", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b6 [6];
        longint     acc [6];
        int         bad;
        int         w;

        tbl[0] = '{16'd4, 8'h55, 4};
        tbl[1] = '{16'd0, 8'hA3, 2};
        tbl[2] = '{16'd1, 8'hA3, 2};
        tbl[3] = '{16'd3, 8'h0F, 3};
        tbl[4] = '{16'd2, 8'hC4, 2};
        tbl[5] = '{16'd5, 8'h80, 5};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ser_tx", ser_tx, 1'b1);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo_level", fifo_level, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Single frames at several divisors
        for (int i = 0; i < 6; i++) run_frame(tbl[i]);

        // Burst of six bytes into a four-deep FIFO
        b6[0] = 8'h11; b6[1] = 8'h22; b6[2] = 8'h93;
        b6[3] = 8'hE4; b6[4] = 8'h05; b6[5] = 8'hB6;
        wait_idle();
        clk_div = 16'd3;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(b6[i]);
                    acc[i] = edge_cnt;
                end
            end
            begin
                logic [7:0] g;
                for (int i = 0; i < 6; i++) begin
                    rx_frame(3, g);
                    check("burst_byte", g, b6[i]);
                end
            end
        join
        for (int i = 1; i < 5; i++) check("burst_accept_consecutive", 32'(acc[i] - acc[0]), i);
        check("burst_sixth_accept_edge", 32'(acc[5] - acc[0]), 33);

        // Divisor change in the middle of a frame
        wait_idle();
        clk_div = 16'd4;
        fork
            begin
                push(8'h3C);
                push(8'hC3);
                clk_div = 16'd8;
            end
            begin
                logic [7:0] g;
                rx_frame(4, g);
                check("divchg_first_byte", g, 8'h3C);
                rx_frame(8, g);
                check("divchg_second_byte", g, 8'hC3);
            end
        join

        // Reset during the data phase of the second of three queued bytes
        wait_idle();
        clk_div = 16'd4;
        fork
            begin
                push(8'hA1);
                push(8'hB2);
                push(8'hC3);
            end
            begin
                logic [7:0] g;
                rx_frame(4, g);
                check("rst_seq_first_byte", g, 8'hA1);
            end
        join
        w = 0;
        while (ser_tx !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) timeout("rst_seq_second_start");
        repeat (14) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_level", fifo_level, 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_ser_tx", ser_tx, 1'b1);
        check("async_rst_in_ready", in_ready, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_level", fifo_level, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ser_tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 0) bad++;
        end
        check("post_rst_quiet_cycles", bad, 0);
        push(8'h5A);
        check("post_rst_first_accept", fifo_level, 1);
        wait_idle();

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 8'($urandom);
            if ($urandom_range(0, 199) == 0) clk_div = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 999) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
